// File: rtl/mbinit_pkg.sv
// ============================================================================
//  Module      : mbinit_pkg
//  Description : State encodings, substate bit indices and defaults shared by
//                the MBINIT sequencer and its timeout counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mbinit_pkg;

    localparam int TIMEOUT_CYCLES_DEFAULT = 800000;
    localparam int CNT_W_DEFAULT          = 20;
    localparam int NUM_SUB                = 6;

    localparam int SUB_PARAM      = 0;
    localparam int SUB_CAL        = 1;
    localparam int SUB_REPAIRCLK  = 2;
    localparam int SUB_REPAIRVAL  = 3;
    localparam int SUB_REVERSALMB = 4;
    localparam int SUB_REPAIRMB   = 5;

    localparam logic [3:0] ST_IDLE       = 4'd0;
    localparam logic [3:0] ST_PARAM      = 4'd1;
    localparam logic [3:0] ST_CAL        = 4'd2;
    localparam logic [3:0] ST_REPAIRCLK  = 4'd3;
    localparam logic [3:0] ST_REPAIRVAL  = 4'd4;
    localparam logic [3:0] ST_REVERSALMB = 4'd5;
    localparam logic [3:0] ST_REPAIRMB   = 4'd6;
    localparam logic [3:0] ST_DONE       = 4'd7;
    localparam logic [3:0] ST_ERROR      = 4'd8;

    function automatic logic is_active(input logic [3:0] st);
        return (st >= ST_PARAM) && (st <= ST_REPAIRMB);
    endfunction

    // One-hot mask of the substate owned by st; zero outside PARAM..REPAIRMB.
    function automatic logic [NUM_SUB-1:0] sub_onehot(input logic [3:0] st);
        logic [NUM_SUB-1:0] mask;
        mask = '0;
        if (is_active(st)) begin
            mask = NUM_SUB'(1) << (st - ST_PARAM);
        end
        return mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ltsm_timeout_counter.sv
// ============================================================================
//  Module      : ltsm_timeout_counter
//  Description : Saturating per-substate cycle counter with synchronous clear
//                and a terminal-count flag, shared by LTSM sequencers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ltsm_timeout_counter #(
    parameter int CNT_W    = 20,
    parameter int TERMINAL = 799999
) (
    input  logic CLK,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    localparam logic [CNT_W-1:0] C_TERM = CNT_W'(TERMINAL);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_enable && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_terminal = (count_q == C_TERM);

endmodule

`default_nettype wire

// File: rtl/mbinit_sequencer.sv
// ============================================================================
//  Module      : mbinit_sequencer
//  Description : Walks the six MBINIT substates in order, with per-substate
//                timeout, error capture and registered next-state outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mbinit_sequencer
    import mbinit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter int CNT_W          = CNT_W_DEFAULT
) (
    input  logic               CLK,
    input  logic               rst_n,
    input  logic               i_MBINIT_en,
    input  logic [NUM_SUB-1:0] i_sub_end,
    input  logic [NUM_SUB-1:0] i_sub_error,
    output logic [NUM_SUB-1:0] o_sub_en,
    output logic               o_MBINIT_done,
    output logic               o_train_error_req,
    output logic               o_timeout,
    output logic [3:0]         o_state
);

    logic [3:0]         state_q, state_d;
    logic [NUM_SUB-1:0] sub_en_q, sub_en_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               timeout_q, timeout_d;

    logic               w_terminal;
    logic               w_active;
    logic               w_tmo;
    logic               w_end;
    logic               w_err;
    logic               w_cnt_clear;

    // Only the end/error bits of the substate currently owned are observed.
    assign w_active    = is_active(state_q);
    assign w_end       = |(i_sub_end & sub_onehot(state_q));
    assign w_err       = |(i_sub_error & sub_onehot(state_q));
    assign w_tmo       = w_active && w_terminal;
    assign w_cnt_clear = (state_d != state_q) || !w_active;

    ltsm_timeout_counter #(
        .CNT_W    (CNT_W),
        .TERMINAL (TIMEOUT_CYCLES - 1)
    ) u_timeout_counter (
        .CLK        (CLK),
        .rst_n      (rst_n),
        .i_clear    (w_cnt_clear),
        .i_enable   (w_active),
        .o_terminal (w_terminal)
    );

    always_comb begin
        state_d = state_q;
        if (!i_MBINIT_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:           state_d = ST_PARAM;
                ST_DONE, ST_ERROR: state_d = state_q;
                ST_PARAM, ST_CAL, ST_REPAIRCLK, ST_REPAIRVAL,
                ST_REVERSALMB, ST_REPAIRMB: begin
                    if (w_err || w_tmo) begin
                        state_d = ST_ERROR;
                    end else if (w_end) begin
                        state_d = (state_q == ST_REPAIRMB) ? ST_DONE : state_q + 4'd1;
                    end
                end
                default:           state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge.
    always_comb begin
        sub_en_d  = sub_onehot(state_d);
        done_d    = (state_d == ST_DONE);
        err_d     = (state_d == ST_ERROR);
        timeout_d = (state_d == ST_ERROR) && ((state_q == ST_ERROR) ? timeout_q : w_tmo);
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sub_en_q  <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sub_en_q  <= sub_en_d;
            done_q    <= done_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_sub_en          = sub_en_q;
    assign o_MBINIT_done     = done_q;
    assign o_train_error_req = err_q;
    assign o_timeout         = timeout_q;
    assign o_state           = state_q;

endmodule

`default_nettype wire

// File: tb/tb_mbinit_sequencer.sv
// ============================================================================
//  Module      : tb_mbinit_sequencer
//  Description : Directed self-checking bench for mbinit_sequencer, run with a
//                16-cycle substate timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mbinit_sequencer;

    logic       CLK;
    logic       rst_n;
    logic       en;
    logic [5:0] sub_end;
    logic [5:0] sub_err;
    logic [5:0] sub_en;
    logic       done;
    logic       terr;
    logic       tmo;
    logic [3:0] state;

    int n_cmp;
    int n_bad;

    mbinit_sequencer #(
        .TIMEOUT_CYCLES (16),
        .CNT_W          (5)
    ) dut (
        .CLK               (CLK),
        .rst_n             (rst_n),
        .i_MBINIT_en       (en),
        .i_sub_end         (sub_end),
        .i_sub_error       (sub_err),
        .o_sub_en          (sub_en),
        .o_MBINIT_done     (done),
        .o_train_error_req (terr),
        .o_timeout         (tmo),
        .o_state           (state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Restart from IDLE and return at the first negedge inside substate state s.
    task automatic go_to(input int s);
        en      = 1'b0;
        sub_end = '0;
        sub_err = '0;
        @(negedge CLK);
        en = 1'b1;
        @(negedge CLK);
        for (int k = 0; k < s - 1; k++) begin
            sub_end[k] = 1'b1;
            @(negedge CLK);
            sub_end = '0;
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        en      = 1'b0;
        sub_end = '0;
        sub_err = '0;
        repeat (2) @(negedge CLK);
        n_cmp++;
        if ({sub_en, done, terr, tmo, state} !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want 0", {sub_en, done, terr, tmo, state});
        end
        rst_n = 1'b1;
        @(negedge CLK);
        n_cmp++;
        if (state !== 4'd0) begin
            n_bad++;
            $display("FAIL idle_hold: state %0d want 0", state);
        end
    endtask

    task automatic test_walk();
        logic [5:0] exp_en;
        en = 1'b1;
        @(negedge CLK);
        n_cmp++;
        if (sub_en !== 6'b000001 || state !== 4'd1) begin
            n_bad++;
            $display("FAIL walk_start: sub_en %b state %0d want 000001/1", sub_en, state);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            exp_en = 6'd1 << k;
            n_cmp++;
            if (sub_en !== exp_en || state !== 4'(k + 1)) begin
                n_bad++;
                $display("FAIL walk_hold%0d: sub_en %b state %0d want %b/%0d", k, sub_en, state, exp_en, k + 1);
            end
            @(negedge CLK);
            sub_end[k] = 1'b1;
            @(negedge CLK);
            sub_end = '0;
            exp_en  = (k < 5) ? (6'd1 << (k + 1)) : 6'd0;
            n_cmp++;
            if (sub_en !== exp_en || state !== 4'(k + 2)) begin
                n_bad++;
                $display("FAIL walk_handoff%0d: sub_en %b state %0d want %b/%0d", k, sub_en, state, exp_en, k + 2);
            end
        end
        n_cmp++;
        if (done !== 1'b1 || terr !== 1'b0 || tmo !== 1'b0) begin
            n_bad++;
            $display("FAIL walk_done: done %b terr %b tmo %b want 1/0/0", done, terr, tmo);
        end
        repeat (3) @(negedge CLK);
        n_cmp++;
        if (state !== 4'd7 || done !== 1'b1) begin
            n_bad++;
            $display("FAIL done_hold: state %0d done %b want 7/1", state, done);
        end
        en = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (state !== 4'd0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL done_exit: state %0d done %b want 0/0", state, done);
        end
    endtask

    task automatic test_error_wins();
        go_to(2);
        sub_err[1] = 1'b1;
        sub_end[1] = 1'b1;
        @(negedge CLK);
        sub_err = '0;
        sub_end = '0;
        n_cmp++;
        if (state !== 4'd8 || terr !== 1'b1 || tmo !== 1'b0 || sub_en !== 6'd0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL error_wins: state %0d terr %b tmo %b sub_en %b want 8/1/0/000000", state, terr, tmo, sub_en);
        end
        repeat (2) @(negedge CLK);
        n_cmp++;
        if (state !== 4'd8 || terr !== 1'b1) begin
            n_bad++;
            $display("FAIL error_hold: state %0d terr %b want 8/1", state, terr);
        end
    endtask

    task automatic test_timeout();
        go_to(4);
        repeat (15) @(negedge CLK);
        n_cmp++;
        if (state !== 4'd4 || sub_en !== 6'b001000) begin
            n_bad++;
            $display("FAIL tmo_cycle16: state %0d sub_en %b want 4/001000", state, sub_en);
        end
        @(negedge CLK);
        n_cmp++;
        if (state !== 4'd8 || tmo !== 1'b1 || terr !== 1'b1 || sub_en !== 6'd0) begin
            n_bad++;
            $display("FAIL tmo_entry: state %0d tmo %b terr %b sub_en %b want 8/1/1/000000", state, tmo, terr, sub_en);
        end
        // End arriving on the 16th cycle still loses to the timeout.
        go_to(4);
        repeat (15) @(negedge CLK);
        sub_end[3] = 1'b1;
        @(negedge CLK);
        sub_end = '0;
        n_cmp++;
        if (state !== 4'd8 || tmo !== 1'b1) begin
            n_bad++;
            $display("FAIL tmo_vs_end: state %0d tmo %b want 8/1", state, tmo);
        end
        en = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (tmo !== 1'b0 || terr !== 1'b0 || state !== 4'd0) begin
            n_bad++;
            $display("FAIL tmo_clear: tmo %b terr %b state %0d want 0/0/0", tmo, terr, state);
        end
        // End on the 15th cycle beats the timeout.
        go_to(4);
        repeat (14) @(negedge CLK);
        sub_end[3] = 1'b1;
        @(negedge CLK);
        sub_end = '0;
        n_cmp++;
        if (state !== 4'd5 || sub_en !== 6'b010000) begin
            n_bad++;
            $display("FAIL end_before_tmo: state %0d sub_en %b want 5/010000", state, sub_en);
        end
    endtask

    task automatic test_disable();
        go_to(5);
        en = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (state !== 4'd0 || sub_en !== 6'd0) begin
            n_bad++;
            $display("FAIL disable: state %0d sub_en %b want 0/000000", state, sub_en);
        end
        en = 1'b1;
        @(negedge CLK);
        n_cmp++;
        if (state !== 4'd1 || sub_en !== 6'b000001) begin
            n_bad++;
            $display("FAIL reenable: state %0d sub_en %b want 1/000001", state, sub_en);
        end
    endtask

    task automatic test_ignore_foreign();
        go_to(1);
        sub_end = 6'b111110;
        sub_err = 6'b111110;
        @(negedge CLK);
        sub_end = 6'b001000;
        sub_err = 6'b100000;
        @(negedge CLK);
        sub_end = '0;
        sub_err = '0;
        n_cmp++;
        if (state !== 4'd1 || sub_en !== 6'b000001 || terr !== 1'b0) begin
            n_bad++;
            $display("FAIL ignore_foreign: state %0d sub_en %b terr %b want 1/000001/0", state, sub_en, terr);
        end
    endtask

    task automatic test_async_reset();
        go_to(6);
        n_cmp++;
        if (sub_en !== 6'b100000) begin
            n_bad++;
            $display("FAIL pre_reset: sub_en %b want 100000", sub_en);
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (sub_en !== 6'd0 || state !== 4'd0) begin
            n_bad++;
            $display("FAIL async_reset: sub_en %b state %0d want 000000/0", sub_en, state);
        end
        @(negedge CLK);
        rst_n = 1'b1;
        en    = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_walk();
        test_error_wins();
        test_timeout();
        test_disable();
        test_ignore_foreign();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
